// File: rtl/dispatch_rs_alloc.sv
// Two-wide dispatch stage: holds up to two decoded instructions, picks the
// lowest free reservation-station entry per class and issues each instruction
// through a registered write port, keeping slot0 strictly ahead of slot1.
//
// Handshake: the decoder pair is transferred on the rising edge where
// in_valid && in_ready; in_ready never depends on in_valid, and the decoder
// must hold its pair stable until that edge.
module dispatch_rs_alloc #(
    parameter int DATA_W = 76,
    parameter int N_CPX  = 2,
    parameter int N_SMP  = 2,
    parameter int N_FP   = 2,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        instA_ctrl,
    input  logic [DATA_W-1:0] instA_data,
    input  logic [1:0]        instB_ctrl,
    input  logic [DATA_W-1:0] instB_data,
    input  logic              flush,
    input  logic [N_CPX-1:0]  cpx_release,
    input  logic [N_SMP-1:0]  smp_release,
    input  logic [N_FP-1:0]   fp_release,
    output logic              wr0_valid,
    output logic [1:0]        wr0_class,
    output logic [IDX_W-1:0]  wr0_idx,
    output logic [DATA_W-1:0] wr0_data,
    output logic              wr1_valid,
    output logic [1:0]        wr1_class,
    output logic [IDX_W-1:0]  wr1_idx,
    output logic [DATA_W-1:0] wr1_data,
    output logic [N_CPX-1:0]  cpx_occ,
    output logic [N_SMP-1:0]  smp_occ,
    output logic [N_FP-1:0]   fp_occ,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] CLS_NOP = 2'b00;
    localparam logic [1:0] CLS_CPX = 2'b01;
    localparam logic [1:0] CLS_FP  = 2'b10;
    localparam logic [1:0] CLS_SMP = 2'b11;

    typedef struct packed {
        logic             ok;
        logic [1:0]       cls;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Lowest clear bit among the first n entries of a busy vector: {found, idx}.
    function automatic logic [IDX_W:0] lowest_free(input logic [7:0] busy, input int n);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!busy[i]) res = {1'b1, IDX_W'(i)};
        end
        return res;
    endfunction

    // Entry choice for one instruction; simple overflows into the complex pool.
    function automatic pick_t pick_entry(input logic [1:0] ctrl, input logic [7:0] cpx_busy,
                                         input logic [7:0] smp_busy, input logic [7:0] fp_busy);
        logic [IDX_W:0] c;
        logic [IDX_W:0] s;
        logic [IDX_W:0] f;
        pick_t          res;
        c   = lowest_free(cpx_busy, N_CPX);
        s   = lowest_free(smp_busy, N_SMP);
        f   = lowest_free(fp_busy, N_FP);
        res = '0;
        case (ctrl)
            CLS_CPX: if (c[IDX_W]) res = {1'b1, CLS_CPX, c[IDX_W-1:0]};
            CLS_FP:  if (f[IDX_W]) res = {1'b1, CLS_FP, f[IDX_W-1:0]};
            CLS_SMP: begin
                if (s[IDX_W])      res = {1'b1, CLS_SMP, s[IDX_W-1:0]};
                else if (c[IDX_W]) res = {1'b1, CLS_CPX, c[IDX_W-1:0]};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Hold buffer, occupancy, write-port and counter state.
    logic              slot0_v_q, slot0_v_d, slot1_v_q, slot1_v_d;
    logic [1:0]        slot0_ctrl_q, slot0_ctrl_d, slot1_ctrl_q, slot1_ctrl_d;
    logic [DATA_W-1:0] slot0_data_q, slot0_data_d, slot1_data_q, slot1_data_d;
    logic [N_CPX-1:0]  cpx_occ_q, cpx_occ_d;
    logic [N_SMP-1:0]  smp_occ_q, smp_occ_d;
    logic [N_FP-1:0]   fp_occ_q, fp_occ_d;
    logic              wr0_valid_q, wr0_valid_d, wr1_valid_q, wr1_valid_d;
    logic [1:0]        wr0_class_q, wr0_class_d, wr1_class_q, wr1_class_d;
    logic [IDX_W-1:0]  wr0_idx_q, wr0_idx_d, wr1_idx_q, wr1_idx_d;
    logic [DATA_W-1:0] wr0_data_q, wr0_data_d, wr1_data_q, wr1_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    pick_t             p0, p1;
    logic              disp0, disp1;
    logic [N_CPX-1:0]  cpx_take0, cpx_take1;
    logic [N_SMP-1:0]  smp_take0, smp_take1;
    logic [N_FP-1:0]   fp_take0, fp_take1;

    // Allocation: slot0 against current occupancy, slot1 against what slot0 leaves.
    always_comb begin
        cpx_take0 = '0;
        cpx_take1 = '0;
        smp_take0 = '0;
        smp_take1 = '0;
        fp_take0  = '0;
        fp_take1  = '0;
        p0    = pick_entry(slot0_ctrl_q, 8'(cpx_occ_q), 8'(smp_occ_q), 8'(fp_occ_q));
        disp0 = slot0_v_q && p0.ok;
        for (int i = 0; i < N_CPX; i++) cpx_take0[i] = disp0 && p0.cls == CLS_CPX && p0.idx == IDX_W'(i);
        for (int i = 0; i < N_SMP; i++) smp_take0[i] = disp0 && p0.cls == CLS_SMP && p0.idx == IDX_W'(i);
        for (int i = 0; i < N_FP; i++)  fp_take0[i]  = disp0 && p0.cls == CLS_FP  && p0.idx == IDX_W'(i);
        p1    = pick_entry(slot1_ctrl_q, 8'(cpx_occ_q | cpx_take0), 8'(smp_occ_q | smp_take0),
                           8'(fp_occ_q | fp_take0));
        disp1 = slot1_v_q && p1.ok && (disp0 || !slot0_v_q);
        for (int i = 0; i < N_CPX; i++) cpx_take1[i] = disp1 && p1.cls == CLS_CPX && p1.idx == IDX_W'(i);
        for (int i = 0; i < N_SMP; i++) smp_take1[i] = disp1 && p1.cls == CLS_SMP && p1.idx == IDX_W'(i);
        for (int i = 0; i < N_FP; i++)  fp_take1[i]  = disp1 && p1.cls == CLS_FP  && p1.idx == IDX_W'(i);
    end

    assign stall    = slot0_v_q && !disp0;
    assign in_ready = (!slot0_v_q || disp0) && (!slot1_v_q || disp1) && !flush;

    // Next state: drain/shift slots, accept a new pair, update pools; flush wins.
    always_comb begin
        slot0_v_d    = slot0_v_q;
        slot0_ctrl_d = slot0_ctrl_q;
        slot0_data_d = slot0_data_q;
        slot1_v_d    = slot1_v_q;
        slot1_ctrl_d = slot1_ctrl_q;
        slot1_data_d = slot1_data_q;
        cpx_occ_d    = (cpx_occ_q & ~cpx_release) | cpx_take0 | cpx_take1;
        smp_occ_d    = (smp_occ_q & ~smp_release) | smp_take0 | smp_take1;
        fp_occ_d     = (fp_occ_q & ~fp_release) | fp_take0 | fp_take1;
        wr0_valid_d  = disp0;
        wr0_class_d  = disp0 ? p0.cls : wr0_class_q;
        wr0_idx_d    = disp0 ? p0.idx : wr0_idx_q;
        wr0_data_d   = disp0 ? slot0_data_q : wr0_data_q;
        wr1_valid_d  = disp1;
        wr1_class_d  = disp1 ? p1.cls : wr1_class_q;
        wr1_idx_d    = disp1 ? p1.idx : wr1_idx_q;
        wr1_data_d   = disp1 ? slot1_data_q : wr1_data_q;
        stall_cnt_d  = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

        if ((!slot0_v_q || disp0) && (!slot1_v_q || disp1)) begin
            slot0_v_d = 1'b0;
            slot1_v_d = 1'b0;
        end else if (!slot0_v_q || disp0) begin
            slot0_v_d    = slot1_v_q;
            slot0_ctrl_d = slot1_ctrl_q;
            slot0_data_d = slot1_data_q;
            slot1_v_d    = 1'b0;
        end

        // Nops are squeezed out so slot0 always holds the oldest real instruction.
        if (in_valid && in_ready) begin
            if (instA_ctrl != CLS_NOP) begin
                slot0_v_d    = 1'b1;
                slot0_ctrl_d = instA_ctrl;
                slot0_data_d = instA_data;
                slot1_v_d    = instB_ctrl != CLS_NOP;
                slot1_ctrl_d = instB_ctrl;
                slot1_data_d = instB_data;
            end else begin
                slot0_v_d    = instB_ctrl != CLS_NOP;
                slot0_ctrl_d = instB_ctrl;
                slot0_data_d = instB_data;
                slot1_v_d    = 1'b0;
            end
        end

        if (flush) begin
            slot0_v_d   = 1'b0;
            slot1_v_d   = 1'b0;
            cpx_occ_d   = '0;
            smp_occ_d   = '0;
            fp_occ_d    = '0;
            wr0_valid_d = 1'b0;
            wr1_valid_d = 1'b0;
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_v_q    <= 1'b0;
            slot0_ctrl_q <= '0;
            slot0_data_q <= '0;
            slot1_v_q    <= 1'b0;
            slot1_ctrl_q <= '0;
            slot1_data_q <= '0;
            cpx_occ_q    <= '0;
            smp_occ_q    <= '0;
            fp_occ_q     <= '0;
            wr0_valid_q  <= 1'b0;
            wr0_class_q  <= '0;
            wr0_idx_q    <= '0;
            wr0_data_q   <= '0;
            wr1_valid_q  <= 1'b0;
            wr1_class_q  <= '0;
            wr1_idx_q    <= '0;
            wr1_data_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            slot0_v_q    <= slot0_v_d;
            slot0_ctrl_q <= slot0_ctrl_d;
            slot0_data_q <= slot0_data_d;
            slot1_v_q    <= slot1_v_d;
            slot1_ctrl_q <= slot1_ctrl_d;
            slot1_data_q <= slot1_data_d;
            cpx_occ_q    <= cpx_occ_d;
            smp_occ_q    <= smp_occ_d;
            fp_occ_q     <= fp_occ_d;
            wr0_valid_q  <= wr0_valid_d;
            wr0_class_q  <= wr0_class_d;
            wr0_idx_q    <= wr0_idx_d;
            wr0_data_q   <= wr0_data_d;
            wr1_valid_q  <= wr1_valid_d;
            wr1_class_q  <= wr1_class_d;
            wr1_idx_q    <= wr1_idx_d;
            wr1_data_q   <= wr1_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign wr0_valid = wr0_valid_q;
    assign wr0_class = wr0_class_q;
    assign wr0_idx   = wr0_idx_q;
    assign wr0_data  = wr0_data_q;
    assign wr1_valid = wr1_valid_q;
    assign wr1_class = wr1_class_q;
    assign wr1_idx   = wr1_idx_q;
    assign wr1_data  = wr1_data_q;
    assign cpx_occ   = cpx_occ_q;
    assign smp_occ   = smp_occ_q;
    assign fp_occ    = fp_occ_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dispatch_rs_alloc.sv
// Directed bench for dispatch_rs_alloc: expected write-port traffic goes into
// per-port queues as pairs are offered and is popped by a monitor whenever a
// port fires; state outputs are compared at fixed points in the sequence.
module tb_dispatch_rs_alloc;

    localparam int DATA_W = 76;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 3;
    localparam int EW     = 2 + IDX_W + DATA_W;

    logic              clk, rst_n;
    logic              in_valid, in_ready, flush;
    logic [1:0]        instA_ctrl, instB_ctrl;
    logic [DATA_W-1:0] instA_data, instB_data;
    logic [1:0]        cpx_release, smp_release, fp_release;
    logic              wr0_valid, wr1_valid;
    logic [1:0]        wr0_class, wr1_class;
    logic [IDX_W-1:0]  wr0_idx, wr1_idx;
    logic [DATA_W-1:0] wr0_data, wr1_data;
    logic [1:0]        cpx_occ, smp_occ, fp_occ;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    logic [EW-1:0]     exp0_q[$];
    logic [EW-1:0]     exp1_q[$];
    int                checks_total = 0;
    int                checks_passed = 0;

    logic [DATA_W-1:0] d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d14, d17, d18, d20, d21;

    dispatch_rs_alloc #(
        .DATA_W(DATA_W), .N_CPX(2), .N_SMP(2), .N_FP(2), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instA_ctrl(instA_ctrl), .instA_data(instA_data),
        .instB_ctrl(instB_ctrl), .instB_data(instB_data), .flush(flush),
        .cpx_release(cpx_release), .smp_release(smp_release), .fp_release(fp_release),
        .wr0_valid(wr0_valid), .wr0_class(wr0_class), .wr0_idx(wr0_idx), .wr0_data(wr0_data),
        .wr1_valid(wr1_valid), .wr1_class(wr1_class), .wr1_idx(wr1_idx), .wr1_data(wr1_data),
        .cpx_occ(cpx_occ), .smp_occ(smp_occ), .fp_occ(fp_occ),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return DATA_W'({$urandom, $urandom, $urandom});
    endfunction

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input int port, input logic [1:0] cls, input int idx,
                          input logic [DATA_W-1:0] d);
        if (port == 0) exp0_q.push_back({cls, IDX_W'(idx), d});
        else           exp1_q.push_back({cls, IDX_W'(idx), d});
    endtask

    task automatic offer(input logic [1:0] ac, input logic [DATA_W-1:0] ad,
                         input logic [1:0] bc, input logic [DATA_W-1:0] bd);
        check("in_ready_before_offer", in_ready, 1'b1);
        instA_ctrl = ac;
        instA_data = ad;
        instB_ctrl = bc;
        instB_data = bd;
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
        instA_ctrl = 2'b00;
        instB_ctrl = 2'b00;
        #1;
    endtask

    task automatic drain_check(input string tag);
        @(negedge clk);
        #1;
        check(tag, 128'(exp0_q.size() + exp1_q.size()), 128'd0);
    endtask

    // Scoreboard: every write-port beat must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr0_valid) begin
                checks_total++;
                assert (exp0_q.size() != 0) checks_passed++;
                else $error("FAIL wr0_spurious: got %0h, expected no write",
                            {wr0_class, wr0_idx, wr0_data});
                if (exp0_q.size() != 0) check("wr0_beat", {wr0_class, wr0_idx, wr0_data}, exp0_q.pop_front());
            end
            if (wr1_valid) begin
                checks_total++;
                assert (exp1_q.size() != 0) checks_passed++;
                else $error("FAIL wr1_spurious: got %0h, expected no write",
                            {wr1_class, wr1_idx, wr1_data});
                if (exp1_q.size() != 0) check("wr1_beat", {wr1_class, wr1_idx, wr1_data}, exp1_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        instA_ctrl = '0; instB_ctrl = '0; instA_data = '0; instB_data = '0;
        cpx_release = '0; smp_release = '0; fp_release = '0;
        d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data(); d4 = rnd_data();
        d5 = rnd_data(); d6 = rnd_data(); d7 = rnd_data(); d8 = rnd_data();
        d9 = rnd_data(); d10 = rnd_data(); d11 = rnd_data(); d14 = rnd_data();
        d17 = rnd_data(); d18 = rnd_data(); d20 = rnd_data(); d21 = rnd_data();

        // Reset values.
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_stall", stall, 1'b0);
        check("rst_occ", {cpx_occ, smp_occ, fp_occ}, 6'b0);
        check("rst_wr_valid", {wr0_valid, wr1_valid}, 2'b0);
        check("rst_wr0_fields", {wr0_class, wr0_idx, wr0_data}, '0);
        check("rst_stall_cnt", stall_cnt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Two simples into an empty simple pool.
        exp_wr(0, 2'b11, 0, d1);
        exp_wr(1, 2'b11, 1, d2);
        offer(2'b11, d1, 2'b11, d2);
        check("t1_in_ready", in_ready, 1'b1);
        check("t1_stall", stall, 1'b0);
        step();
        check("t1_smp_occ", smp_occ, 2'b11);
        check("t1_cpx_occ", cpx_occ, 2'b00);
        drain_check("t1_drain");

        // Simple pool full: both spill into complex entries.
        exp_wr(0, 2'b01, 0, d3);
        exp_wr(1, 2'b01, 1, d4);
        step();
        offer(2'b11, d3, 2'b11, d4);
        step();
        check("t2_cpx_occ", cpx_occ, 2'b11);
        drain_check("t2_drain");

        // Free everything, then take fp entry 0.
        step();
        cpx_release = 2'b11; smp_release = 2'b11;
        step();
        cpx_release = 2'b00; smp_release = 2'b00;
        check("rel_occ", {cpx_occ, smp_occ}, 4'b0);
        exp_wr(0, 2'b10, 0, d5);
        offer(2'b10, d5, 2'b00, '0);
        step();
        check("fp_setup_occ", fp_occ, 2'b01);
        drain_check("fp_setup_drain");

        // fp pair with one free entry: slot1 shifts and stalls until a release.
        step();
        exp_wr(0, 2'b10, 1, d6);
        offer(2'b10, d6, 2'b10, d7);
        check("t3_in_ready_partial", in_ready, 1'b0);
        check("t3_no_stall_first", stall, 1'b0);
        step();
        check("t3_stall", stall, 1'b1);
        check("t3_in_ready_stalled", in_ready, 1'b0);
        check("t3_fp_full", fp_occ, 2'b11);
        check("t3_cnt0", stall_cnt, 3'd0);
        fp_release = 2'b01;
        exp_wr(0, 2'b10, 0, d7);
        step();
        fp_release = 2'b00;
        #1;
        check("t3_cnt1", stall_cnt, 3'd1);
        check("t3_fp_after_rel", fp_occ, 2'b10);
        check("t3_unstalled", stall, 1'b0);
        check("t3_in_ready_back", in_ready, 1'b1);
        step();
        check("t3_fp_refill", fp_occ, 2'b11);
        drain_check("t3_drain");

        // Complex full: complex-then-simple pair blocked in order.
        step();
        exp_wr(0, 2'b01, 0, d8);
        exp_wr(1, 2'b01, 1, d9);
        offer(2'b01, d8, 2'b01, d9);
        step();
        check("t4_cpx_full", cpx_occ, 2'b11);
        drain_check("t4_fill_drain");
        step();
        offer(2'b01, d10, 2'b11, d11);
        check("t4_stall_a", stall, 1'b1);
        check("t4_in_ready", in_ready, 1'b0);
        check("t4_cnt_a", stall_cnt, 3'd1);
        step();
        check("t4_cnt_b", stall_cnt, 3'd2);
        step();
        check("t4_cnt_c", stall_cnt, 3'd3);
        check("t4_smp_unused", smp_occ, 2'b00);
        cpx_release = 2'b10;
        exp_wr(0, 2'b01, 1, d10);
        exp_wr(1, 2'b11, 0, d11);
        step();
        cpx_release = 2'b00;
        #1;
        check("t4_cnt_d", stall_cnt, 3'd4);
        check("t4_cpx_after_rel", cpx_occ, 2'b01);
        check("t4_unstalled", stall, 1'b0);
        step();
        check("t4_occ_after", {cpx_occ, smp_occ}, 4'b11_01);
        drain_check("t4_drain");

        // Nop pairs.
        step();
        offer(2'b00, rnd_data(), 2'b00, rnd_data());
        check("t5_nop_ready", in_ready, 1'b1);
        check("t5_nop_stall", stall, 1'b0);
        step();
        check("t5_nop_occ", {cpx_occ, smp_occ, fp_occ}, 6'b11_01_11);
        fp_release = 2'b11;
        step();
        fp_release = 2'b00;
        check("t5_fp_freed", fp_occ, 2'b00);
        exp_wr(0, 2'b10, 0, d14);
        offer(2'b00, rnd_data(), 2'b10, d14);
        step();
        check("t5_fp_occ", fp_occ, 2'b01);
        drain_check("t5_drain");

        // Flush with held slots and busy pools; stall count survives.
        step();
        offer(2'b01, rnd_data(), 2'b01, rnd_data());
        check("t6_stall", stall, 1'b1);
        check("t6_cnt_a", stall_cnt, 3'd4);
        step();
        check("t6_cnt_b", stall_cnt, 3'd5);
        flush = 1'b1;
        #1;
        check("t6_ready_in_flush", in_ready, 1'b0);
        step();
        flush = 1'b0;
        #1;
        check("t6_occ_cleared", {cpx_occ, smp_occ, fp_occ}, 6'b0);
        check("t6_wr_valid", {wr0_valid, wr1_valid}, 2'b0);
        check("t6_stall_cleared", stall, 1'b0);
        check("t6_ready_after", in_ready, 1'b1);
        check("t6_cnt_kept", stall_cnt, 3'd5);
        step();
        check("t6_cnt_still", stall_cnt, 3'd5);
        drain_check("t6_drain");

        // Counter saturation, then asynchronous reset mid-stall.
        step();
        exp_wr(0, 2'b01, 0, d17);
        exp_wr(1, 2'b01, 1, d18);
        offer(2'b01, d17, 2'b01, d18);
        step();
        drain_check("t7_fill_drain");
        step();
        offer(2'b01, rnd_data(), 2'b00, '0);
        check("t7_stall", stall, 1'b1);
        step();
        step();
        check("t7_cnt_top", stall_cnt, 3'd7);
        step();
        step();
        check("t7_cnt_sat", stall_cnt, 3'd7);
        check("t7_stall_hold", stall, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_async_cnt", stall_cnt, 3'd0);
        check("t7_async_stall", stall, 1'b0);
        check("t7_async_ready", in_ready, 1'b1);
        check("t7_async_occ", {cpx_occ, smp_occ, fp_occ}, 6'b0);
        check("t7_async_wr", {wr0_valid, wr1_valid, wr0_class, wr0_idx}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        exp_wr(0, 2'b11, 0, d20);
        exp_wr(1, 2'b10, 0, d21);
        offer(2'b11, d20, 2'b10, d21);
        step();
        check("t7_post_occ", {cpx_occ, smp_occ, fp_occ}, 6'b00_01_01);
        drain_check("t7_drain");
        step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/dispatch_rs_alloc.md
Name: dispatch_rs_alloc

Overview:
- Parametrised two-wide dispatch stage with entry allocation and in-order stall handling.
- Holds up to two decoded instructions and tracks occupancy of the complex, simple and FP reservation-station pools.
- Allocates the lowest free entry per class and writes each instruction into its entry through two registered write ports.
- Sits between the decoder and the distributed RS; RS entries report frees through release vectors.

Parameters:
- DATA_W, 76, RS payload width per instruction.
- N_CPX, 2, number of complex RS entries (1..8).
- N_SMP, 2, number of simple RS entries (1..8).
- N_FP, 2, number of FP RS entries (1..8).
- IDX_W, 3, entry index width; must satisfy 2**IDX_W >= max(N_CPX, N_SMP, N_FP).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoder offers an instruction pair.
- in_ready  out  1  pair accepted at the edge where in_valid && in_ready.
- instA_ctrl  in  2  dispatch class of the older instruction: 00 nop, 01 complex, 11 simple, 10 fp.
- instA_data  in  DATA_W  payload of the older instruction.
- instB_ctrl  in  2  dispatch class of the younger instruction.
- instB_data  in  DATA_W  payload of the younger instruction.
- flush  in  1  pipeline flush.
- cpx_release  in  N_CPX  per-entry free pulse from the complex RS.
- smp_release  in  N_SMP  per-entry free pulse from the simple RS.
- fp_release  in  N_FP  per-entry free pulse from the FP RS.
- wr0_valid  out  1  write-port 0 carries an instruction.
- wr0_class  out  2  target pool of port 0: 01 complex, 11 simple, 10 fp.
- wr0_idx  out  IDX_W  target entry of port 0.
- wr0_data  out  DATA_W  payload on port 0.
- wr1_valid, wr1_class, wr1_idx, wr1_data  out  same widths  write-port 1.
- cpx_occ  out  N_CPX  complex occupancy bits.
- smp_occ  out  N_SMP  simple occupancy bits.
- fp_occ  out  N_FP  FP occupancy bits.
- stall  out  1  oldest held instruction is blocked this cycle.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: hold slots empty; all occupancy bits 0; wr*_valid/class/idx/data 0; stall_cnt 0; in_ready 1; stall 0.
- Hold buffer: slot0 (older) and slot1; each slot has a valid bit, ctrl and data. Nop instructions (ctrl 00) are never stored; a slot is loaded valid only if its ctrl != 00.
- Allocation is combinational from registered state each cycle:
  - Slot0 is tried first against current occupancy.
  - Slot1 is tried against occupancy minus slot0's pick.
  - Complex (01): lowest free complex entry.
  - FP (10): lowest free FP entry.
  - Simple (11): lowest free simple entry; if no simple entry is free, lowest free complex entry, reported with class 01.
- In-order rule: slot1 may dispatch only if slot0 dispatches or slot0 is empty.
- Outcomes at the clock edge:
  - Both slots dispatch: both slots clear.
  - Only slot0 dispatches: slot1 shifts into slot0 and slot1 clears.
  - Neither dispatches: both slots hold.
- in_ready = every valid held slot dispatches this cycle (1 when the buffer is empty), and !flush.
- On accept, instA loads slot0 and instB loads slot1. If only instB is non-nop, it loads slot0.
- Write ports are registered with 1-cycle latency:
  - The slot0 dispatch drives wr0 at the next edge; the slot1 dispatch drives wr1 at the same edge.
  - wr*_valid is 0 in cycles with no dispatch on that port.
- Occupancy update: occ_next = (occ & ~release) | alloc_set.
  - Alloc uses pre-release occupancy, so an entry released in cycle N is allocatable in cycle N+1.
  - A release pulse on an unoccupied entry is ignored.
- stall = slot0 valid && slot0 not dispatching. stall_cnt increments while stall is 1 and saturates at all-ones.
- Flush has priority over dispatch and accept:
  - At the edge it clears both hold slots and all occupancy bits.
  - wr*_valid is 0 in the next cycle; in_ready is 0 during the flush cycle.
  - stall_cnt is preserved.
- Asynchronous reset mid-operation returns all state to reset values immediately; in-flight writes are dropped.

Test Plan:
- Reset, then pair (11,11), all pools empty → next cycle wr0 = simple idx0, wr1 = simple idx1; smp_occ = 11; in_ready stays 1.
- Simple pool full, cpx_occ = 00, pair (11,11) → wr0 = complex idx0, wr1 = complex idx1; cpx_occ = 11.
- fp_occ = 01, pair (10,10) → wr0 = fp idx1; slot1 holds with stall = 1 and in_ready = 0. Pulse fp_release = 01 → next cycle wr0 = fp idx0 (shifted slot) and stall_cnt = 1.
- cpx_occ = 11, pair (01,11), simple empty → in-order rule blocks both; stall = 1 every cycle, stall_cnt counts. Release cpx entry 1 → wr0 = complex idx1, wr1 = simple idx0.
- Pair (00,00) with in_valid → accepted, no wr*_valid, occupancy unchanged. Pair (00,10) → wr0 = fp idx0.
- Slots held and occupancy nonzero, assert flush → next cycle slots empty, all occ = 0, wr*_valid = 0, stall_cnt unchanged. Drop rst_n mid-stall → all outputs go to reset values asynchronously.
